// File: rtl/div_pkg.sv
// Shared types and default widths for the 16-by-8 restoring divider.
package div_pkg;

    localparam int DVD_W_DEF = 16;
    localparam int DVS_W_DEF = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DVD_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/divider_16by8bits_if.sv
// Operand/result bundle of the divider; dbz exists only when DIV_DBZ_FLAG_EN is defined.
interface divider_16by8bits_if #(
    parameter int DVD_W = div_pkg::DVD_W_DEF,
    parameter int DVS_W = div_pkg::DVS_W_DEF
) ();

    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             done;
    logic             busy;
    logic [1:0]       s;
`ifdef DIV_DBZ_FLAG_EN
    logic             dbz;

    modport master (output start, dividend, divisor,
                    input  quotient, remainder, done, busy, s, dbz);
    modport slave  (input  start, dividend, divisor,
                    output quotient, remainder, done, busy, s, dbz);
`else
    modport master (output start, dividend, divisor,
                    input  quotient, remainder, done, busy, s);
    modport slave  (input  start, dividend, divisor,
                    output quotient, remainder, done, busy, s);
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step
    import div_pkg::*;
#(
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic [DVS_W:0]   r_in,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   r_out,
    output logic             q_bit
);

    logic [DVS_W:0] shifted_s;
    logic [DVS_W:0] diff_s;
    logic           ge_s;

    // A set top bit in r_in means the true shifted value exceeds any divisor.
    always_comb begin
        shifted_s = {r_in[DVS_W-1:0], bit_in};
        diff_s    = shifted_s - {1'b0, divisor};
        ge_s      = r_in[DVS_W] | (shifted_s >= {1'b0, divisor});
        if (ge_s) begin
            r_out = diff_s;
            q_bit = 1'b1;
        end else begin
            r_out = shifted_s;
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/divider_16by8bits.sv
// Sequential unsigned divider, one quotient bit per clock, MSB first.
// Optional divide-by-zero short-cut and dbz flag under macro DIV_DBZ_FLAG_EN.
module divider_16by8bits
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input logic                  clk,
    input logic                  reset,
    divider_16by8bits_if.slave   bus
);

    localparam int CW = cnt_width(DVD_W);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [DVS_W:0]   prem_q,  prem_d;
    logic [DVD_W-1:0] work_q,  work_d;
    logic [DVS_W-1:0] dvs_q,   dvs_d;
    logic [DVD_W-1:0] quot_q,  quot_d;
    logic [DVS_W-1:0] rmd_q,   rmd_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;
`ifdef DIV_DBZ_FLAG_EN
    logic             zdiv_q,  zdiv_d;
    logic             dbz_q,   dbz_d;
`endif

    logic [DVS_W:0]   step_rem_s;
    logic             step_bit_s;

    // work_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    div_step #(.DVS_W(DVS_W)) u_step (
        .r_in    (prem_q),
        .bit_in  (work_q[DVD_W-1]),
        .divisor (dvs_q),
        .r_out   (step_rem_s),
        .q_bit   (step_bit_s)
    );

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        done_d  = 1'b0;
`ifdef DIV_DBZ_FLAG_EN
        zdiv_d  = zdiv_q;
        dbz_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.dividend;
                    dvs_d   = bus.divisor;
                    prem_d  = {(DVS_W+1){1'b0}};
                    cnt_d   = CW'(DVD_W - 1);
                    state_d = CALC;
`ifdef DIV_DBZ_FLAG_EN
                    if (bus.divisor == {DVS_W{1'b0}}) begin
                        zdiv_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        zdiv_d  = 1'b0;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prem_d = step_rem_s;
                work_d = {work_q[DVD_W-2:0], step_bit_s};
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef DIV_DBZ_FLAG_EN
                if (zdiv_q) begin
                    quot_d = {DVD_W{1'b1}};
                    rmd_d  = work_q[DVS_W-1:0];
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = work_q;
                    rmd_d  = prem_q[DVS_W-1:0];
                end
`else
                quot_d = work_q;
                rmd_d  = prem_q[DVS_W-1:0];
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CALC) || (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            prem_q  <= {(DVS_W+1){1'b0}};
            work_q  <= {DVD_W{1'b0}};
            dvs_q   <= {DVS_W{1'b0}};
            quot_q  <= {DVD_W{1'b0}};
            rmd_q   <= {DVS_W{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
            zdiv_q  <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef DIV_DBZ_FLAG_EN
            zdiv_q  <= zdiv_d;
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rmd_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.s         = state_q;
`ifdef DIV_DBZ_FLAG_EN
    assign bus.dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_divider_16by8bits.sv
// Self-checking bench for divider_16by8bits: directed cases, random back-to-back stream, reset abort.
module tb_divider_16by8bits;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef DIV_DBZ_FLAG_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    divider_16by8bits_if #(.DVD_W(16), .DVS_W(8)) bus ();

    divider_16by8bits #(.DVD_W(16), .DVS_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: plain arithmetic, with the all-ones/low-byte convention for a zero divisor.
    function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                    output logic [15:0] q, output logic [7:0] r, output int lat);
        if (b == 8'd0) begin
            q   = 16'hFFFF;
            r   = a[7:0];
            lat = DBZ_EN ? 1 : 17;
        end else begin
            q   = a / {8'd0, b};
            r   = 8'(a % {8'd0, b});
            lat = 17;
        end
    endfunction

    function automatic logic get_dbz();
`ifdef DIV_DBZ_FLAG_EN
        return bus.dbz;
`else
        return 1'b0;
`endif
    endfunction

    // Launch one division from IDLE; returns results, accept-to-done latency and whether done appeared.
    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           output logic [15:0] q, output logic [7:0] r, output logic z,
                           output int lat, output bit ok);
        q = 16'd0; r = 8'd0; z = 1'b0; ok = 1'b0; lat = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                q  = bus.quotient;
                r  = bus.remainder;
                z  = get_dbz();
            end else if (lat == 4) begin
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0; bus.dividend = 16'd0; bus.divisor = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.quotient !== 16'd0) begin n_fail++; $display("FAIL reset_quotient got %0h want 0", bus.quotient); end
        n_tests++; if (bus.remainder !== 8'd0) begin n_fail++; $display("FAIL reset_remainder got %0h want 0", bus.remainder); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.s !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", bus.s); end
        n_tests++; if (get_dbz() !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", get_dbz()); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] ta [7];
        logic [7:0]  tb [7];
        logic [15:0] tq [7];
        logic [7:0]  tr [7];
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        int          elat;
        bit          ok;
        ta = '{16'd1000, 16'd65535, 16'd0, 16'd12,     16'd300, 16'd255, 16'd254};
        tb = '{8'd7,     8'd255,    8'd5,  8'd0,       8'd1,    8'd255,  8'd255};
        tq = '{16'd142,  16'd257,   16'd0, 16'hFFFF,   16'd300, 16'd1,   16'd0};
        tr = '{8'd6,     8'd0,      8'd0,  8'd12,      8'd0,    8'd0,    8'd254};
        for (int k = 0; k < 7; k++) begin
            elat = (tb[k] == 8'd0 && DBZ_EN) ? 1 : 17;
            run_div(ta[k], tb[k], q, r, z, lat, ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL directed_timeout case %0d no done within 40 cycles", k);
            end else begin
                if (q !== tq[k] || r !== tr[k]) begin
                    n_fail++; $display("FAIL directed_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", ta[k], tb[k], q, r, tq[k], tr[k]);
                end
                n_tests++;
                if (lat != elat) begin n_fail++; $display("FAIL directed_latency %0d/%0d got %0d want %0d", ta[k], tb[k], lat, elat); end
                n_tests++;
                if (z !== (DBZ_EN && tb[k] == 8'd0)) begin n_fail++; $display("FAIL directed_dbz %0d/%0d got %b want %b", ta[k], tb[k], z, DBZ_EN && tb[k] == 8'd0); end
                @(negedge clk);
                n_tests++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b0 || get_dbz() !== 1'b0) begin
                    n_fail++; $display("FAIL directed_pulse done=%b busy=%b dbz=%b want 0 0 0 one cycle later", bus.done, bus.busy, get_dbz());
                end
                n_tests++;
                if (bus.quotient !== tq[k] || bus.remainder !== tr[k]) begin
                    n_fail++; $display("FAIL directed_hold got q=%0d r=%0d want q=%0d r=%0d", bus.quotient, bus.remainder, tq[k], tr[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa [$];
        logic [7:0]  qb [$];
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        int          elat;
        int          cyc = 0, last_done = 0, since = 0, seen = 0;
        bit          timeout = 1'b0;
        @(negedge clk);
        a = 16'($urandom); b = 8'($urandom);
        qa.push_back(a); qb.push_back(b);
        bus.dividend = a; bus.divisor = b; bus.start = 1'b1;
        while (seen < 1000 && !timeout) begin
            @(negedge clk);
            cyc++; since++;
            if (bus.done === 1'b1) begin
                a = qa.pop_front(); b = qb.pop_front();
                ref_div(a, b, eq, er, elat);
                n_tests++;
                if (bus.quotient !== eq || bus.remainder !== er || get_dbz() !== (DBZ_EN && b == 8'd0)) begin
                    n_fail++; $display("FAIL b2b_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", a, b, bus.quotient, bus.remainder, eq, er);
                end
                if (seen > 0) begin
                    n_tests++;
                    if (cyc - last_done != elat + 1) begin
                        n_fail++; $display("FAIL b2b_period %0d/%0d got %0d cycles want %0d", a, b, cyc - last_done, elat + 1);
                    end
                end
                last_done = cyc;
                seen++;
                since = 0;
                if (seen < 1000) begin
                    a = 16'($urandom); b = 8'($urandom);
                    qa.push_back(a); qb.push_back(b);
                    bus.dividend = a; bus.divisor = b;
                end
            end else if (since == 6) begin
                bus.dividend = 16'($urandom);
                bus.divisor  = 8'($urandom);
            end else if (since > 40) begin
                timeout = 1'b1;
                n_tests++; n_fail++;
                $display("FAIL b2b_timeout no done after %0d cycles at result %0d", since, seen);
            end
        end
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        int          dones = 0;
        bit          ok;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.quotient !== 16'd0 || bus.remainder !== 8'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.s !== 2'b00 || get_dbz() !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs got q=%0d r=%0d done=%b busy=%b s=%b want all 0", bus.quotient, bus.remainder, bus.done, bus.busy, bus.s);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        n_tests++;
        if (dones != 0) begin n_fail++; $display("FAIL midreset_nodone got %0d active cycles want 0", dones); end
        run_div(16'd200, 8'd9, q, r, z, lat, ok);
        n_tests++;
        if (!ok || q !== 16'd22 || r !== 8'd2 || lat != 17) begin
            n_fail++; $display("FAIL midreset_next got ok=%0d q=%0d r=%0d lat=%0d want q=22 r=2 lat=17", ok, q, r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_calc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
